alu_serial_sequencer: RTL and testbench
=======================================

Name: alu_serial_sequencer

Overview:
- Bit-serial controller that runs a full WIDTH-bit ALU operation through a single-bit slice datapath, one bit per clock, LSB first.
- Holds the carry between cycles, shifts the result in, and finalises SLT and the status flags.
- Sits between the register-file read stage and writeback in the small-area ALU build.
- Uses valid/ready handshakes on both the command side and the result side.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).
- CNT_W, 5, bit-counter width; must be at least clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd_op  input  3  0=ADD, 1=SUB, 2=XOR, 3=SLT, 4..7=illegal
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- res_valid  output  1  result held stable
- res_ready  input  1  consumer takes the result
- res_data  output  WIDTH  result
- res_cout  output  1  carry out of the MSB (ADD/SUB/SLT), else 0
- res_ovf  output  1  signed overflow (ADD/SUB only), else 0
- res_zero  output  1  res_data == 0
- res_err  output  1  illegal opcode
- busy  output  1  state is not IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, cmd_ready=1, res_valid=0.
  - res_data=0, res_cout=0, res_ovf=0, res_zero=0, res_err=0, busy=0.
  - Counter=0, carry register=0.
- Command accept: in IDLE, when cmd_valid && cmd_ready are both high on a clock edge:
  - Latch op, a and b into shift registers.
  - Carry register <= op[0] for SUB/SLT (the +1 of the two's complement); otherwise 0.
  - Counter <= 0.
  - Illegal op goes to DONE with res_err=1 and res_data=0; otherwise go to RUN.
- RUN (WIDTH cycles, counter 0..WIDTH-1), per cycle:
  - bin = b[0] XOR sub, where sub=1 for SUB/SLT.
  - sum = a[0]^bin^carry.
  - cnext = majority(a[0], bin, carry).
  - xbit = a[0]^b[0], using the raw b.
  - Shift sum (or xbit for XOR) into the result MSB; shift a and b right.
  - Carry register <= cnext.
  - On counter==WIDTH-1, capture cin_msb = carry entering the MSB and cout = cnext. For SLT, also capture sum_msb.
- Exit RUN: SLT goes to FIX; all other ops go to DONE.
- FIX (1 cycle, SLT only): res_data <= {WIDTH-1 zeros, sum_msb XOR (cin_msb XOR cout)}.
- DONE:
  - res_valid=1; all res_* outputs are stable until res_ready.
  - On res_valid && res_ready: go to IDLE, drop res_valid. The next command is accepted no earlier than the following edge (no same-cycle turnaround).
- Flags:
  - res_cout = cout for ADD/SUB/SLT; 0 for XOR or an illegal op.
  - res_ovf = cin_msb XOR cout for ADD/SUB only.
  - res_zero is computed on the final res_data, including SLT and error cases. An error case therefore gives zero=1.
- Latency, accept edge to res_valid high:
  - WIDTH+1 cycles for ADD/SUB/XOR.
  - WIDTH+2 cycles for SLT.
  - 1 cycle for an illegal op.
- cmd_* changes while busy are ignored. res_ready while not in DONE is ignored.
- Counter wraps only through re-initialisation on accept; it never exceeds WIDTH-1.

Test Plan:
- ADD, WIDTH=32: a=0xFFFFFFFF, b=1 -> after 33 cycles res_data=0, cout=1, ovf=0, zero=1.
- SUB: a=0x80000000, b=1 -> res_data=0x7FFFFFFF, cout=1, ovf=1, zero=0.
- SLT:
  - a=0xFFFFFFFE (-2), b=3 -> res_data=1 after 34 cycles.
  - a=0x7FFFFFFF, b=0x80000000 -> res_data=0 (overflow-corrected).
- XOR then backpressure: a=0xA5A5A5A5, b=0xFFFF0000 -> res_data=0x5A5AA5A5; hold res_ready=0 for 5 cycles -> outputs stable, cmd_ready=0.
- Illegal op 5: -> res_valid the next cycle, err=1, res_data=0, zero=1. Then ADD 2+3 -> res_data=5, err=0.
- Reset at counter=10 during ADD -> all outputs at reset values immediately, no res_valid. A new ADD 7+8 afterwards -> res_data=15.

Source files
------------

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: pushes a WIDTH-bit ADD/SUB/XOR/SLT through a one-bit slice, LSB first,
// then holds the result and status flags behind a valid/ready handshake.
module alu_serial_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_zero,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SLT = 3'd3;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CNT_W-1:0] cnt;
  logic             carry, cin_msb, cout_q, sum_msb, err_q;

  logic accept, cmd_legal, cmd_sub, sub, bin, sum, cnext, xbit, last;

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    cmd_legal = (cmd_op <= OP_SLT);
    cmd_sub   = (cmd_op == OP_SUB) || (cmd_op == OP_SLT);
    sub       = (op_q == OP_SUB) || (op_q == OP_SLT);
    bin       = b_q[0] ^ sub;
    sum       = a_q[0] ^ bin ^ carry;
    cnext     = (a_q[0] & bin) | (a_q[0] & carry) | (bin & carry);
    xbit      = a_q[0] ^ b_q[0];
    last      = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = cmd_legal ? RUN : DONE;
      RUN:  if (last)   state_nxt = (op_q == OP_SLT) ? FIX : DONE;
      FIX:              state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Datapath: operands shift right, result fills from the MSB so it lands aligned after WIDTH steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
      cout_q  <= 1'b0;
      sum_msb <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q    <= cmd_op;
          a_q     <= cmd_a;
          b_q     <= cmd_b;
          carry   <= cmd_sub ? cmd_op[0] : 1'b0;
          cnt     <= '0;
          cin_msb <= 1'b0;
          cout_q  <= 1'b0;
          sum_msb <= 1'b0;
          err_q   <= !cmd_legal;
          if (!cmd_legal) res_q <= '0;
        end
        RUN: begin
          res_q <= {((op_q == OP_XOR) ? xbit : sum), res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= cnext;
          if (last) begin
            cin_msb <= carry;
            cout_q  <= cnext;
            sum_msb <= sum;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Signed less-than: sign of a-b corrected by the overflow bit.
        FIX: res_q <= {{(WIDTH-1){1'b0}}, sum_msb ^ cin_msb ^ cout_q};
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    res_valid = (state == DONE);
    res_data  = res_q;
    res_err   = err_q;
    res_cout  = cout_q & ((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT));
    res_ovf   = (cin_msb ^ cout_q) & ((op_q == OP_ADD) || (op_q == OP_SUB));
    res_zero  = (state == DONE) && (res_q == '0);
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer: hand-computed vectors covering each op, backpressure,
// illegal opcodes and an asynchronous reset in the middle of a run.
module tb_alu_serial_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_cout, res_ovf, res_zero, res_err, busy;

  int nvec  = 0;
  int nfail = 0;
  int lat;

  alu_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_ovf(res_ovf), .res_zero(res_zero),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one command, waits for the accept edge, then counts edges until res_valid (bounded).
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = '0;
    cmd_b     = '0;
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [31:0] data, input logic cout,
                             input logic ovf, input logic zero, input logic err, input int explat);
    checkOutput({tag, ".latency"}, lat, explat);
    checkOutput({tag, ".valid"}, {31'd0, res_valid}, 32'd1);
    checkOutput({tag, ".data"}, res_data, data);
    checkOutput({tag, ".cout"}, {31'd0, res_cout}, {31'd0, cout});
    checkOutput({tag, ".ovf"}, {31'd0, res_ovf}, {31'd0, ovf});
    checkOutput({tag, ".zero"}, {31'd0, res_zero}, {31'd0, zero});
    checkOutput({tag, ".err"}, {31'd0, res_err}, {31'd0, err});
  endtask

  task automatic releaseResult(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput({tag, ".valid_drop"}, {31'd0, res_valid}, 32'd0);
    checkOutput({tag, ".ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    #12;
    checkOutput("reset.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset.res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.res_data", res_data, 32'd0);
    checkOutput("reset.flags", {28'd0, res_cout, res_ovf, res_zero, res_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h1);
    checkResult("add_wrap", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 33);
    releaseResult("add_wrap");

    applyStimulus(3'd1, 32'h8000_0000, 32'h1);
    checkResult("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 33);
    releaseResult("sub_ovf");

    applyStimulus(3'd3, 32'hFFFF_FFFE, 32'h3);
    checkResult("slt_neg", 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 34);
    releaseResult("slt_neg");

    applyStimulus(3'd3, 32'h7FFF_FFFF, 32'h8000_0000);
    checkResult("slt_ovf", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 34);
    releaseResult("slt_ovf");

    applyStimulus(3'd2, 32'hA5A5_A5A5, 32'hFFFF_0000);
    checkResult("xor", 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 33);
    // Hold the result under backpressure while a stray command is offered; it must be ignored.
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_a     = 32'h1234;
    cmd_b     = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp.valid", {31'd0, res_valid}, 32'd1);
      checkOutput("bp.data", res_data, 32'h5A5A_A5A5);
      checkOutput("bp.cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    releaseResult("xor");

    applyStimulus(3'd5, 32'hDEAD_BEEF, 32'h1);
    checkResult("illegal", 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    releaseResult("illegal");

    applyStimulus(3'd0, 32'h2, 32'h3);
    checkResult("add_small", 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 33);
    releaseResult("add_small");

    // Abort an ADD part-way through with an asynchronous reset.
    @(negedge clk);
    cmd_op    = 3'd0;
    cmd_a     = 32'h1111_1111;
    cmd_b     = 32'h2222_2222;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset.busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("midreset.res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("midreset.res_data", res_data, 32'd0);
    checkOutput("midreset.flags", {28'd0, res_cout, res_ovf, res_zero, res_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postreset.res_valid", {31'd0, res_valid}, 32'd0);

    applyStimulus(3'd0, 32'h7, 32'h8);
    checkResult("add_after_reset", 32'hF, 1'b0, 1'b0, 1'b0, 1'b0, 33);
    releaseResult("add_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
